pipe_adder: RTL

- Parametrised, elastic, pipelined successor to the single-cycle C-modelled adder.
- Adds, subtracts, or accumulates WIDTH-bit operands with a WIDTH+1-bit result.
- Uses valid/ready handshakes on both sides and sustains one result per cycle.
- Used as the reference arithmetic datapath in adder testbenches and as a building block for streaming DSP paths.

---
 rtl/pipe_adder_pkg.sv | 20 ++
 rtl/pipe_adder_if.sv | 32 +++
 rtl/pipe_slice.sv | 44 ++++
 rtl/pipe_adder.sv | 105 ++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// rtl/pipe_adder_pkg.sv - shared types and helpers for the pipelined adder
//
// Purpose : operation encoding and result-width helper used by the
//           interface, the top level and the bench.
// Ports   : none (package).
package pipe_adder_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_ACC  = 2'd2,
        OP_LOAD = 2'd3
    } op_t;

    // Results carry one extra bit above the operand width (carry/borrow).
    function automatic int result_width(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// rtl/pipe_adder_if.sv - valid/ready stream bundle for the pipelined adder
//
// Purpose : groups the operand-side and result-side handshakes.
// Ports   : i_valid/o_ready/i_op/i_a/i_b (operand side),
//           o_valid/i_ready/o_sum/o_wrap (result side).
//           slave  = the adder, master = the producer/consumer driving it.
interface pipe_adder_if #(
    parameter int WIDTH = 16
);
    import pipe_adder_pkg::*;

    logic                           i_valid;
    logic                           o_ready;
    op_t                            i_op;
    logic [WIDTH-1:0]               i_a;
    logic [WIDTH-1:0]               i_b;
    logic                           o_valid;
    logic                           i_ready;
    logic [result_width(WIDTH)-1:0] o_sum;
    logic                           o_wrap;

    modport master (
        output i_valid, i_op, i_a, i_b, i_ready,
        input  o_ready, o_valid, o_sum, o_wrap
    );

    modport slave (
        input  i_valid, i_op, i_a, i_b, i_ready,
        output o_ready, o_valid, o_sum, o_wrap
    );

endinterface

// File: rtl/pipe_slice.sv
// rtl/pipe_slice.sv - single valid/ready register slice
//
// Purpose : one elastic pipeline register; holds its payload while the
//           downstream side stalls and accepts a new beat while draining.
// Ports   : clk, rst (async, active high)
//           in_valid/in_ready/in_data   upstream handshake and payload
//           out_valid/out_ready/out_data downstream handshake and payload
module pipe_slice #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // Space exists when empty or when the current beat leaves this edge.
    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            if (in_ready) begin
                valid_q <= in_valid;
            end
            // Payload only moves with a real beat, so it stays put while stalled.
            if (in_valid && in_ready) begin
                data_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - elastic pipelined add/sub/accumulate datapath
//
// Purpose : computes ADD/SUB/ACC/LOAD on the accepted beat, then carries
//           {wrap, sum} through STAGES register slices to the output.
// Ports   : clk  rising-edge clock
//           rst  asynchronous active-high reset
//           bus  pipe_adder_if.slave (operand and result handshakes)
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    pipe_adder_if.slave  bus
);

    localparam int RW = result_width(WIDTH);
    localparam int PW = RW + 1;

    logic [RW-1:0] acc;
    logic [RW-1:0] acc_nxt;
    logic [RW-1:0] a_ext;
    logic [RW-1:0] b_ext;
    logic [RW:0]   acc_sum;
    logic [RW-1:0] res;
    logic          wrap;
    logic          accept;
    logic          acc_we;

    logic          vld [STAGES+1];
    logic          rdy [STAGES+1];
    logic [PW-1:0] dat [STAGES+1];

    // Stage 0: operation evaluated on the incoming beat against the current
    // accumulator, so consecutive ACC beats chain without bubbles.
    always_comb begin
        a_ext   = {1'b0, bus.i_a};
        b_ext   = {1'b0, bus.i_b};
        acc_sum = {1'b0, acc} + {1'b0, a_ext};
        res     = a_ext + b_ext;
        wrap    = 1'b0;
        acc_nxt = acc;
        acc_we  = 1'b0;
        unique case (bus.i_op)
            OP_ADD: begin
                res = a_ext + b_ext;
            end
            OP_SUB: begin
                res = a_ext - b_ext;
            end
            OP_ACC: begin
                res     = acc_sum[RW-1:0];
                wrap    = acc_sum[RW];
                acc_nxt = acc_sum[RW-1:0];
                acc_we  = 1'b1;
            end
            OP_LOAD: begin
                res     = a_ext;
                acc_nxt = a_ext;
                acc_we  = 1'b1;
            end
            default: begin
                res = a_ext + b_ext;
            end
        endcase
    end

    assign accept = bus.i_valid && rdy[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (accept && acc_we) begin
            acc <= acc_nxt;
        end
    end

    assign vld[0]      = bus.i_valid;
    assign dat[0]      = {wrap, res};
    assign rdy[STAGES] = bus.i_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        pipe_slice #(
            .W (PW)
        ) u_slice (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (vld[k]),
            .in_ready  (rdy[k]),
            .in_data   (dat[k]),
            .out_valid (vld[k+1]),
            .out_ready (rdy[k+1]),
            .out_data  (dat[k+1])
        );
    end

    // o_ready depends on slice state and i_ready only, never on i_valid.
    assign bus.o_ready = rdy[0];
    assign bus.o_valid = vld[STAGES];
    assign bus.o_wrap  = dat[STAGES][PW-1];
    assign bus.o_sum   = dat[STAGES][RW-1:0];

endmodule
